// File: rtl/csm_arbiter_if.sv
// rtl/csm_arbiter_if.sv - requester A/B and memory-port bundle for csm_arbiter
// Purpose: groups both processor-side request ports and the single memory port.
// slave  : arbiter view (requests in; grants, errors, lock status, read data and memory strobes out).
// master : environment view (processors and memory array).
interface csm_arbiter_if #(
  parameter int DATABITS = 8,
  parameter int ADDRBITS = 3
);
  logic                a_req, a_rw, a_hold, a_release;
  logic [ADDRBITS-1:0] a_addr;
  logic [DATABITS-1:0] a_wdata;
  logic                a_ack, a_locked, a_rvalid;
  logic [1:0]          a_err;
  logic [DATABITS-1:0] a_rdata;

  logic                b_req, b_rw, b_hold, b_release;
  logic [ADDRBITS-1:0] b_addr;
  logic [DATABITS-1:0] b_wdata;
  logic                b_ack, b_locked, b_rvalid;
  logic [1:0]          b_err;
  logic [DATABITS-1:0] b_rdata;

  logic                mem_en, mem_we;
  logic [ADDRBITS-1:0] mem_addr;
  logic [DATABITS-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  a_req, a_rw, a_addr, a_wdata, a_hold, a_release,
    input  b_req, b_rw, b_addr, b_wdata, b_hold, b_release,
    output a_ack, a_err, a_locked, a_rvalid, a_rdata,
    output b_ack, b_err, b_locked, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_rw, a_addr, a_wdata, a_hold, a_release,
    output b_req, b_rw, b_addr, b_wdata, b_hold, b_release,
    input  a_ack, a_err, a_locked, a_rvalid, a_rdata,
    input  b_ack, b_err, b_locked, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/csm_arbiter.sv
// rtl/csm_arbiter.sv - two-requester round-robin memory arbiter with hold/release lock
// Purpose: serialises A/B accesses onto one single-port memory, with an exclusive lock
// that auto-releases after LOCK_TIMEOUT idle owner cycles.
// Ports: clk, reset (synchronous, active high); bus (csm_arbiter_if.slave) carrying
// A/B req/rw/addr/wdata/hold/release in, ack/err/locked/rvalid/rdata out, and the
// memory port mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in.
module csm_arbiter #(
  parameter int DATABITS     = 8,
  parameter int MEMSIZE      = 8,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  csm_arbiter_if.slave bus
);
  localparam int ADDRBITS = $clog2(MEMSIZE);
  localparam int TBITS    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TBITS-1:0] TMR_LAST = TBITS'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_IN_USE     = 2'b01;
  localparam logic [1:0] ERR_DUAL_WRITE = 2'b10;
  localparam logic [1:0] ERR_DUAL_HOLD  = 2'b11;

  typedef enum logic [1:0] { LK_NONE, LK_OWN_A, LK_OWN_B } lock_e;

  lock_e               lock_q, lock_d, eff_lock;
  logic [TBITS-1:0]    tmr_q, tmr_d;
  logic                rr_b_q, rr_b_d;       // 1: B wins the next contention
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [1:0]          a_err_q, a_err_d, b_err_q, b_err_d;
  logic                a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDRBITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATABITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                a_req_v, b_req_v, own_req, own_rel;

  always_comb begin
    // A request presented while its ack is showing belongs to the access just issued.
    a_req_v  = bus.a_req & ~a_ack_q;
    b_req_v  = bus.b_req & ~b_ack_q;
    a_err_d  = ERR_NONE;
    b_err_d  = ERR_NONE;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    rr_b_d   = rr_b_q;

    // A hold taken this cycle already governs this cycle's grant; a release only
    // takes effect from the next cycle.
    eff_lock = lock_q;
    case (lock_q)
      LK_NONE: begin
        if (bus.a_hold & bus.b_hold) begin
          a_err_d = ERR_DUAL_HOLD;
          b_err_d = ERR_DUAL_HOLD;
        end else if (bus.a_hold) begin
          eff_lock = LK_OWN_A;
        end else if (bus.b_hold) begin
          eff_lock = LK_OWN_B;
        end
      end
      LK_OWN_A: if (bus.b_hold) b_err_d = ERR_IN_USE;
      LK_OWN_B: if (bus.a_hold) a_err_d = ERR_IN_USE;
      default: ;
    endcase

    case (eff_lock)
      LK_OWN_A: begin
        a_ack_d = a_req_v;
        if (b_req_v) b_err_d = ERR_IN_USE;
      end
      LK_OWN_B: begin
        b_ack_d = b_req_v;
        if (a_req_v) a_err_d = ERR_IN_USE;
      end
      default: begin
        if (a_req_v & b_req_v) begin
          a_ack_d = ~rr_b_q;
          b_ack_d = rr_b_q;
          rr_b_d  = ~rr_b_q;
          // Colliding writes: the loser is rejected rather than left waiting.
          if (bus.a_rw & bus.b_rw & (bus.a_addr == bus.b_addr)) begin
            if (rr_b_q) begin
              if (a_err_d == ERR_NONE) a_err_d = ERR_DUAL_WRITE;
            end else if (b_err_d == ERR_NONE) begin
              b_err_d = ERR_DUAL_WRITE;
            end
          end
        end else begin
          a_ack_d = a_req_v;
          b_ack_d = b_req_v;
        end
      end
    endcase

    mem_en_d    = a_ack_d | b_ack_d;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (a_ack_d) begin
      mem_we_d    = bus.a_rw;
      mem_addr_d  = bus.a_addr;
      mem_wdata_d = bus.a_wdata;
    end else if (b_ack_d) begin
      mem_we_d    = bus.b_rw;
      mem_addr_d  = bus.b_addr;
      mem_wdata_d = bus.b_wdata;
    end

    a_rvalid_d = a_ack_q & ~mem_we_q;
    b_rvalid_d = b_ack_q & ~mem_we_q;

    // Idle counter runs only while an owner holds the lock without requesting.
    own_req = (lock_q == LK_OWN_A) ? bus.a_req     : bus.b_req;
    own_rel = (lock_q == LK_OWN_A) ? bus.a_release : bus.b_release;
    lock_d  = lock_q;
    tmr_d   = '0;
    if (lock_q == LK_NONE) begin
      lock_d = eff_lock;
    end else if (own_rel) begin
      lock_d = LK_NONE;
    end else if (!own_req) begin
      if (tmr_q == TMR_LAST) lock_d = LK_NONE;
      else                   tmr_d  = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q      <= LK_NONE;
      tmr_q       <= '0;
      rr_b_q      <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_err_q     <= ERR_NONE;
      b_err_q     <= ERR_NONE;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      lock_q      <= lock_d;
      tmr_q       <= tmr_d;
      rr_b_q      <= rr_b_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_err     = a_err_q;
  assign bus.b_err     = b_err_q;
  assign bus.a_locked  = (lock_q == LK_OWN_A);
  assign bus.b_locked  = (lock_q == LK_OWN_B);
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  // Read data is the memory's output, forced to zero outside its valid cycle.
  assign bus.a_rdata   = a_rvalid_q ? bus.mem_rdata : '0;
  assign bus.b_rdata   = b_rvalid_q ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_csm_arbiter.sv
// tb/tb_csm_arbiter.sv - self-checking bench for csm_arbiter
module tb_csm_arbiter;
  localparam int DW = 8;
  localparam int MS = 8;
  localparam int AW = 3;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  csm_arbiter_if #(.DATABITS(DW), .ADDRBITS(AW)) bus ();
  csm_arbiter #(.DATABITS(DW), .MEMSIZE(MS), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_arr [MS];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MS; i++) mem_arr[i] <= '0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  // Reference model state
  int            m_owner;   // 0 none, 1 A, 2 B
  int            m_idle;
  bit            m_fav_b;
  logic [DW-1:0] m_shadow [MS];
  logic [DW-1:0] m_rd;
  logic          e_a_ack, e_b_ack, e_a_rvalid, e_b_rvalid, e_mem_en, e_mem_we;
  logic [1:0]    e_a_err, e_b_err;
  logic [DW-1:0] e_a_rdata, e_b_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;

  function automatic logic [63:0] all_outs();
    return 64'({bus.a_ack, bus.a_err, bus.a_locked, bus.a_rvalid, bus.a_rdata,
                bus.b_ack, bus.b_err, bus.b_locked, bus.b_rvalid, bus.b_rdata,
                bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_rw = 0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_hold = 0; bus.a_release = 0;
    bus.b_req = 0; bus.b_rw = 0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_hold = 0; bus.b_release = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_owner = 0; m_idle = 0; m_fav_b = 0; m_rd = '0;
    for (int i = 0; i < MS; i++) m_shadow[i] = '0;
    e_a_ack = 0; e_b_ack = 0; e_a_rvalid = 0; e_b_rvalid = 0; e_mem_en = 0; e_mem_we = 0;
    e_a_err = 0; e_b_err = 0; e_a_rdata = 0; e_b_rdata = 0; e_mem_wdata = 0; e_mem_addr = 0;
  endtask

  // Applies the arbitration rules to the inputs sampled at this edge.
  task automatic model_step();
    bit ra, rb, ga, gb, n_a_rv, n_b_rv, o_req, o_rel;
    logic [1:0] ea, eb;
    int eff;
    n_a_rv = e_a_ack && !e_mem_we;
    n_b_rv = e_b_ack && !e_mem_we;
    e_a_rdata = n_a_rv ? m_rd : '0;
    e_b_rdata = n_b_rv ? m_rd : '0;
    e_a_rvalid = n_a_rv;
    e_b_rvalid = n_b_rv;
    ra = bus.a_req && !e_a_ack;
    rb = bus.b_req && !e_b_ack;
    ea = 0; eb = 0; ga = 0; gb = 0;
    eff = m_owner;
    if (m_owner == 0) begin
      if (bus.a_hold && bus.b_hold) begin ea = 3; eb = 3; end
      else if (bus.a_hold) eff = 1;
      else if (bus.b_hold) eff = 2;
    end else if (m_owner == 1 && bus.b_hold) eb = 1;
    else if (m_owner == 2 && bus.a_hold) ea = 1;
    if (eff == 1) begin
      ga = ra; if (rb) eb = 1;
    end else if (eff == 2) begin
      gb = rb; if (ra) ea = 1;
    end else if (ra && rb) begin
      if (m_fav_b) gb = 1; else ga = 1;
      m_fav_b = ga;
      if (bus.a_rw && bus.b_rw && bus.a_addr == bus.b_addr) begin
        if (ga && eb == 0) eb = 2;
        if (gb && ea == 0) ea = 2;
      end
    end else begin
      ga = ra; gb = rb;
    end
    if (m_owner == 0) begin
      m_owner = eff; m_idle = 0;
    end else begin
      o_req = (m_owner == 1) ? bus.a_req : bus.b_req;
      o_rel = (m_owner == 1) ? bus.a_release : bus.b_release;
      if (o_rel) begin m_owner = 0; m_idle = 0; end
      else if (o_req) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) begin m_owner = 0; m_idle = 0; end
      end
    end
    e_a_ack = ga; e_b_ack = gb; e_a_err = ea; e_b_err = eb;
    e_mem_en = ga | gb;
    e_mem_we = ga ? bus.a_rw : (gb ? bus.b_rw : 1'b0);
    e_mem_addr = ga ? bus.a_addr : (gb ? bus.b_addr : '0);
    e_mem_wdata = ga ? bus.a_wdata : (gb ? bus.b_wdata : '0);
    if (e_mem_en) begin
      if (e_mem_we) m_shadow[e_mem_addr] = e_mem_wdata;
      else          m_rd = m_shadow[e_mem_addr];
    end
  endtask

  task automatic test_reset();
    logic [63:0] got, exp;
    do_reset();
    got = all_outs(); exp = 64'd0; n_total++;
    if (got !== exp) $display("FAIL reset_outs: got %h want %h", got, exp); else n_pass++;
    cyc();
    got = all_outs(); n_total++;
    if (got !== exp) $display("FAIL reset_idle: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [63:0] got, exp;
    do_reset();
    bus.a_req = 1; bus.a_rw = 1; bus.a_addr = 3'd3; bus.a_wdata = 8'h5A;
    cyc();
    got = 64'({bus.a_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    exp = 64'({1'b1, 1'b1, 1'b1, 3'd3, 8'h5A}); n_total++;
    if (got !== exp) $display("FAIL t1_write: got %h want %h", got, exp); else n_pass++;
    bus.a_rw = 0; bus.a_wdata = 8'h00;
    cyc();
    got = 64'({bus.a_ack, bus.mem_en}); exp = 64'd0; n_total++;
    if (got !== exp) $display("FAIL t1_req_in_ack_ignored: got %h want %h", got, exp); else n_pass++;
    cyc();
    got = 64'({bus.a_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.a_rvalid});
    exp = 64'({1'b1, 1'b1, 1'b0, 3'd3, 1'b0}); n_total++;
    if (got !== exp) $display("FAIL t1_read_ack: got %h want %h", got, exp); else n_pass++;
    bus.a_req = 0;
    cyc();
    got = 64'({bus.a_ack, bus.a_rvalid, bus.a_rdata}); exp = 64'({1'b0, 1'b1, 8'h5A}); n_total++;
    if (got !== exp) $display("FAIL t1_rdata: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [63:0] got, exp;
    do_reset();
    bus.a_req = 1; bus.a_addr = 3'd1; bus.b_req = 1; bus.b_addr = 3'd6;
    for (int k = 0; k < 5; k++) begin
      cyc();
      got = 64'({bus.a_ack, bus.b_ack, bus.mem_en, bus.a_err, bus.b_err});
      exp = 64'({(k % 2 == 0) ? 1'b1 : 1'b0, (k % 2 == 1) ? 1'b1 : 1'b0, 1'b1, 2'b00, 2'b00}); n_total++;
      if (got !== exp) $display("FAIL t2_alternate[%0d]: got %h want %h", k, got, exp); else n_pass++;
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_dual_write();
    logic [63:0] got, exp;
    do_reset();
    bus.a_req = 1; bus.a_rw = 1; bus.a_addr = 3'd2; bus.a_wdata = 8'h11;
    bus.b_req = 1; bus.b_rw = 1; bus.b_addr = 3'd2; bus.b_wdata = 8'h22;
    cyc();
    got = 64'({bus.a_ack, bus.b_ack, bus.mem_wdata, bus.a_err, bus.b_err});
    exp = 64'({1'b1, 1'b0, 8'h11, 2'b00, 2'b10}); n_total++;
    if (got !== exp) $display("FAIL t3_dual_write: got %h want %h", got, exp); else n_pass++;
    bus.a_req = 0;
    cyc();
    got = 64'({bus.a_ack, bus.b_ack, bus.mem_wdata, bus.b_err});
    exp = 64'({1'b0, 1'b1, 8'h22, 2'b00}); n_total++;
    if (got !== exp) $display("FAIL t3_rearb: got %h want %h", got, exp); else n_pass++;
    idle_inputs();
    cyc();
  endtask

  task automatic test_lock();
    logic [63:0] got, exp;
    do_reset();
    bus.a_hold = 1;
    cyc();
    bus.a_hold = 0;
    got = 64'({bus.a_locked, bus.b_locked}); exp = 64'({1'b1, 1'b0}); n_total++;
    if (got !== exp) $display("FAIL t4_locked: got %h want %h", got, exp); else n_pass++;
    bus.b_req = 1; bus.b_addr = 3'd1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      got = 64'({bus.a_locked, bus.b_ack, bus.b_err}); exp = 64'({1'b1, 1'b0, 2'b01}); n_total++;
      if (got !== exp) $display("FAIL t4_in_use[%0d]: got %h want %h", k, got, exp); else n_pass++;
    end
    bus.a_release = 1;
    cyc();
    bus.a_release = 0;
    got = 64'({bus.a_locked, bus.b_ack}); exp = 64'd0; n_total++;
    if (got !== exp) $display("FAIL t4_release: got %h want %h", got, exp); else n_pass++;
    cyc();
    got = 64'({bus.b_ack, bus.b_err, bus.mem_en}); exp = 64'({1'b1, 2'b00, 1'b1}); n_total++;
    if (got !== exp) $display("FAIL t4_b_grant: got %h want %h", got, exp); else n_pass++;
    idle_inputs();
    cyc();
  endtask

  task automatic test_timeout();
    logic [63:0] got, exp;
    do_reset();
    bus.a_hold = 1;
    cyc();
    bus.a_hold = 0; bus.b_req = 1; bus.b_addr = 3'd5;
    for (int k = 1; k <= TO; k++) begin
      cyc();
      got = 64'({bus.a_locked, bus.b_ack}); exp = 64'({(k < TO) ? 1'b1 : 1'b0, 1'b0}); n_total++;
      if (got !== exp) $display("FAIL t5_idle[%0d]: got %h want %h", k, got, exp); else n_pass++;
    end
    cyc();
    got = 64'({bus.b_ack, bus.b_err}); exp = 64'({1'b1, 2'b00}); n_total++;
    if (got !== exp) $display("FAIL t5_b_grant: got %h want %h", got, exp); else n_pass++;
    bus.b_req = 0; bus.a_hold = 1; bus.b_hold = 1;
    cyc();
    bus.a_hold = 0; bus.b_hold = 0;
    got = 64'({bus.a_err, bus.b_err, bus.a_locked, bus.b_locked}); exp = 64'({2'b11, 2'b11, 2'b00}); n_total++;
    if (got !== exp) $display("FAIL t5_dual_hold: got %h want %h", got, exp); else n_pass++;
    cyc();
    got = 64'({bus.a_err, bus.b_err, bus.a_locked, bus.b_locked}); exp = 64'd0; n_total++;
    if (got !== exp) $display("FAIL t5_no_lock: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, exp;
    do_reset();
    bus.a_req = 1; bus.a_addr = 3'd3;
    cyc();
    got = 64'(bus.a_ack); exp = 64'd1; n_total++;
    if (got !== exp) $display("FAIL t6_read_ack: got %h want %h", got, exp); else n_pass++;
    reset = 1'b1; bus.a_req = 0;
    cyc();
    got = all_outs(); exp = 64'd0; n_total++;
    if (got !== exp) $display("FAIL t6_reset_outs: got %h want %h", got, exp); else n_pass++;
    reset = 1'b0;
    cyc();
    got = all_outs(); n_total++;
    if (got !== exp) $display("FAIL t6_no_rvalid: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] got, exp;
    bit a_act, b_act;
    do_reset();
    model_reset();
    a_act = 0; b_act = 0;
    for (int i = 0; i < 3000; i++) begin
      got = 64'({bus.a_ack, bus.a_err, bus.a_locked, bus.a_rvalid, bus.a_rdata});
      exp = 64'({e_a_ack, e_a_err, (m_owner == 1) ? 1'b1 : 1'b0, e_a_rvalid, e_a_rdata}); n_total++;
      if (got !== exp) $display("FAIL rand_a[%0d]: got %h want %h", i, got, exp); else n_pass++;
      got = 64'({bus.b_ack, bus.b_err, bus.b_locked, bus.b_rvalid, bus.b_rdata});
      exp = 64'({e_b_ack, e_b_err, (m_owner == 2) ? 1'b1 : 1'b0, e_b_rvalid, e_b_rdata}); n_total++;
      if (got !== exp) $display("FAIL rand_b[%0d]: got %h want %h", i, got, exp); else n_pass++;
      got = 64'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
      exp = 64'({e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata}); n_total++;
      if (got !== exp) $display("FAIL rand_mem[%0d]: got %h want %h", i, got, exp); else n_pass++;

      if (e_a_ack) a_act = 0;
      if (!a_act && $urandom_range(0, 1) == 1) begin
        a_act = 1;
        bus.a_rw = 1'($urandom_range(0, 1));
        bus.a_addr = 3'($urandom_range(0, 3));
        bus.a_wdata = 8'($urandom);
      end else if (a_act && $urandom_range(0, 15) == 0) a_act = 0;
      if (e_b_ack) b_act = 0;
      if (!b_act && $urandom_range(0, 1) == 1) begin
        b_act = 1;
        bus.b_rw = 1'($urandom_range(0, 1));
        bus.b_addr = 3'($urandom_range(0, 3));
        bus.b_wdata = 8'($urandom);
      end else if (b_act && $urandom_range(0, 15) == 0) b_act = 0;
      bus.a_req = a_act;
      bus.b_req = b_act;
      bus.a_hold = ($urandom_range(0, 15) == 0);
      bus.b_hold = ($urandom_range(0, 15) == 0);
      bus.a_release = ($urandom_range(0, 23) == 0);
      bus.b_release = ($urandom_range(0, 23) == 0);

      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_alternate();
    test_dual_write();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
